// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 single-bit mux. The select, the one-hot grant and the
// new-grant pulse are registered. Grants are length-bounded, and handover happens with no idle cycle.
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       gnt_new,
  output logic       dout
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_GRANT  = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             gnt_new_q, gnt_new_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic       end_grant;
  logic [2:0] search_base;
  logic [7:0] req_rot;
  logic       win_found;
  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic       mux_out;

  // While granting, the search starts one past the grantee, so the grantee is considered last.
  assign search_base = (state_q == ST_GRANT) ? sel_q + 3'd1 : ptr_q;
  assign end_grant   = !req[sel_q] || (hold_cnt_q == HOLD_LAST);

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign req_rot[gi] = req[search_base + 3'(gi)];
  end

  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) win_off = 3'(i);
    end
    win_found = |req_rot;
    win_idx   = search_base + win_off;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    gnt_new_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          sel_d      = win_idx;
          gnt_d      = 8'b1 << win_idx;
          gnt_new_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!end_grant) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          ptr_d = sel_q + 3'd1;
          if (win_found) begin
            sel_d      = win_idx;
            gnt_d      = 8'b1 << win_idx;
            gnt_new_d  = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d    = ST_IDLE;
            gnt_d      = 8'h00;
            hold_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        gnt_d      = 8'h00;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 3'd0;
      ptr_q      <= 3'd0;
      gnt_q      <= 8'h00;
      gnt_new_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gnt_new_q  <= gnt_new_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // The shared datapath mux is gated so that an idle channel never shows data from the last select.
  assign mux_out = din[sel_q];
  assign dout    = (state_q == ST_GRANT) ? mux_out : 1'b0;

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == ST_GRANT);
  assign gnt_new = gnt_new_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Checks two arbiters (HOLD_MAX 4 and 16) sharing one stimulus against a queue-free ownership model
// that tracks which source owns the channel and for how many cycles.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;

  logic [7:0] gnt_o     [2];
  logic [2:0] sel_o     [2];
  logic       busy_o    [2];
  logic       gnt_new_o [2];
  logic       dout_o    [2];

  int compared   = 0;
  int mismatched = 0;

  int owner [2];
  int held  [2];
  int ptr   [2];
  int last  [2];
  bit newp  [2];

  mux8_rr_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .busy(busy_o[0]), .gnt_new(gnt_new_o[0]), .dout(dout_o[0])
  );

  mux8_rr_arbiter #(.HOLD_MAX(16), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .busy(busy_o[1]), .gnt_new(gnt_new_o[1]), .dout(dout_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hold_max(input int k);
    return (k == 0) ? 4 : 16;
  endfunction

  function automatic int find_winner(input logic [7:0] r, input int from);
    for (int i = 0; i < 8; i++) begin
      if (r[(from + i) % 8]) return (from + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; held[k] = 0; ptr[k] = 0; last[k] = 0; newp[k] = 1'b0;
    end
  endtask

  task automatic take(input int k, input int w);
    owner[k] = w; last[k] = w; held[k] = 1; newp[k] = 1'b1;
  endtask

  task automatic model_edge();
    int w;
    for (int k = 0; k < 2; k++) begin
      newp[k] = 1'b0;
      if (owner[k] < 0) begin
        w = find_winner(req, ptr[k]);
        if (w >= 0) take(k, w);
      end else if (!req[owner[k]] || held[k] == hold_max(k)) begin
        ptr[k] = (owner[k] + 1) % 8;
        w = find_winner(req, ptr[k]);
        if (w >= 0) take(k, w);
        else owner[k] = -1;
      end else begin
        held[k]++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s t=%0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_gnt;
    logic       e_dout;
    for (int k = 0; k < 2; k++) begin
      e_gnt  = (owner[k] >= 0) ? (8'h01 << owner[k]) : 8'h00;
      e_dout = (owner[k] >= 0) ? din[owner[k]] : 1'b0;
      check($sformatf("%s[%0d].gnt", tag, k),     gnt_o[k],           e_gnt);
      check($sformatf("%s[%0d].sel", tag, k),     {5'd0, sel_o[k]},   8'(last[k]));
      check($sformatf("%s[%0d].busy", tag, k),    {7'd0, busy_o[k]},  {7'd0, owner[k] >= 0});
      check($sformatf("%s[%0d].gnt_new", tag, k), {7'd0, gnt_new_o[k]}, {7'd0, newp[k]});
      check($sformatf("%s[%0d].dout", tag, k),    {7'd0, dout_o[k]},  {7'd0, e_dout});
    end
    if (newp[0])
      $display("[%0t] %s: A grants src %0d (req=%h)", $time, tag, owner[0], req);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called just after a step: asserts reset between edges and releases it before the next edge.
  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    din   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Single requester, data path, release.
    req = 8'h08; din = 8'h08;
    step("single");
    check("single_gnt_const", gnt_o[0], 8'h08);
    check("single_dout_const", {7'd0, dout_o[0]}, 8'h01);
    req = 8'h00;
    step("single_drop");
    check("drop_busy_const", {7'd0, busy_o[0]}, 8'h00);

    // Full rotation under constant pressure.
    req = 8'hFF;
    repeat (40) begin
      din = 8'($urandom);
      step("rotate");
    end
    req = 8'h00;
    repeat (2) step("idle");

    // Timeout regrant with a single source.
    req = 8'h04;
    repeat (40) step("regrant");
    req = 8'h00;
    step("idle");

    // Early release and wrap past 7.
    req = 8'h20; step("wrap"); step("wrap");
    req = 8'h43; step("wrap"); step("wrap"); step("wrap");
    req = 8'h03; repeat (3) step("wrap");
    req = 8'h43; repeat (6) step("wrap");
    req = 8'h00; step("idle");

    // Simultaneous release and new request.
    req = 8'h08; step("handover"); step("handover");
    req = 8'h10; step("handover");
    check("handover_busy_const", {7'd0, busy_o[0]}, 8'h01);
    req = 8'h00; step("idle");

    // Reset mid-grant, then regrant of source 5.
    req = 8'h20; step("rst_mid"); step("rst_mid");
    mid_reset();
    step("rst_after");
    check("rst_after_gnt_const", gnt_o[1], 8'h20);
    step("rst_after");

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0:       req = 8'($urandom);
        1:       req = 8'h00;
        2, 3:    req = req ^ (8'h01 << $urandom_range(0, 7));
        default: ;
      endcase
      din = 8'($urandom);
      step("random");
      if ($urandom_range(0, 120) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
